// File: rtl/mem_wb_fifo_if.sv
// LSU-to-writeback bundle interface: the LSU push side (s_*) and the WB-facing head side.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; valid never depends on ready.
interface mem_wb_fifo_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CSR_AW = 12
);
  logic              s_valid_i;
  logic              s_ready_o;
  logic              s_rd_we_i;
  logic [RA_W-1:0]   s_rd_wa_i;
  logic [XLEN-1:0]   s_rd_wd_i;
  logic              s_csr_we_i;
  logic [CSR_AW-1:0] s_csr_wa_i;
  logic [XLEN-1:0]   s_csr_wd_i;

  logic              m_valid_o;
  logic              m_ready_i;
  logic              rd_we_o;
  logic [RA_W-1:0]   rd_wa_o;
  logic [XLEN-1:0]   rd_wd_o;
  logic              csr_we_o;
  logic [CSR_AW-1:0] csr_wa_o;
  logic [XLEN-1:0]   csr_wd_o;
  logic              instret_incr_o;

  modport slave (
    input  s_valid_i, s_rd_we_i, s_rd_wa_i, s_rd_wd_i, s_csr_we_i, s_csr_wa_i, s_csr_wd_i,
    input  m_ready_i,
    output s_ready_o, m_valid_o, rd_we_o, rd_wa_o, rd_wd_o, csr_we_o, csr_wa_o, csr_wd_o,
    output instret_incr_o
  );

  modport master (
    output s_valid_i, s_rd_we_i, s_rd_wa_i, s_rd_wd_i, s_csr_we_i, s_csr_wa_i, s_csr_wd_i,
    output m_ready_i,
    input  s_ready_o, m_valid_o, rd_we_o, rd_wa_o, rd_wd_o, csr_we_o, csr_wa_o, csr_wd_o,
    input  instret_incr_o
  );
endinterface

// File: rtl/mem_wb_fifo.sv
// DEPTH-entry FIFO between LSU and writeback; write strobes and instret fire only on the pop,
// so each bundle is written back exactly once no matter how long WB stalls.
module mem_wb_fifo #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int CSR_AW  = 12,
  parameter int DEPTH   = 2,
  parameter int DROP_X0 = 1
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic                     flush_i,
  mem_wb_fifo_if.slave             bus,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic              rd_we;
    logic [RA_W-1:0]   rd_wa;
    logic [XLEN-1:0]   rd_wd;
    logic              csr_we;
    logic [CSR_AW-1:0] csr_wa;
    logic [XLEN-1:0]   csr_wd;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            s_ready;
  logic            m_valid;
  logic            push;
  logic            pop;
  logic            x0_hit;

  // Ready comes from registered occupancy only, so a full buffer refuses even a same-cycle pop slot.
  assign s_ready = (count_q < DEPTH_C);
  assign m_valid = (count_q != '0) & ~flush_i;
  assign push    = bus.s_valid_i & s_ready & ~flush_i;
  assign pop     = m_valid & bus.m_ready_i;
  assign head    = mem_q[rd_ptr_q];
  assign x0_hit  = (DROP_X0 != 0) && (head.rd_wa == '0);

  always_comb begin
    wr_entry        = '0;
    wr_entry.rd_we  = bus.s_rd_we_i;
    wr_entry.rd_wa  = bus.s_rd_wa_i;
    wr_entry.rd_wd  = bus.s_rd_wd_i;
    wr_entry.csr_we = bus.s_csr_we_i;
    wr_entry.csr_wa = bus.s_csr_wa_i;
    wr_entry.csr_wd = bus.s_csr_wd_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    bus.s_ready_o      = s_ready;
    bus.m_valid_o      = m_valid;
    bus.rd_wa_o        = '0;
    bus.rd_wd_o        = '0;
    bus.csr_wa_o       = '0;
    bus.csr_wd_o       = '0;
    bus.rd_we_o        = pop & head.rd_we & ~x0_hit;
    bus.csr_we_o       = pop & head.csr_we;
    bus.instret_incr_o = pop;
    if (m_valid) begin
      bus.rd_wa_o  = head.rd_wa;
      bus.rd_wd_o  = head.rd_wd;
      bus.csr_wa_o = head.csr_wa;
      bus.csr_wd_o = head.csr_wd;
    end
  end

  assign count_o = count_q;
endmodule
